// File: rtl/muldiv_unit.sv
// Iterative 64-bit MUL/UMULH/UDIV/SDIV unit feeding the register-file write port.
// A shared 128-bit accumulator serves as product register (mul) or remainder:quotient (div).
module muldiv_unit #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       dest,
  output logic             busy,
  output logic             done,
  output logic             write,
  output logic [4:0]       sel_w,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_UMULH = 2'b01;
  localparam logic [1:0] OP_SDIV  = 2'b11;
  localparam int unsigned ACC_W   = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         op_q;
  logic               neg_q;
  logic [WIDTH-1:0]   opb_q;
  logic [ACC_W-1:0]   acc_q;
  logic               busy_q;
  logic               done_q;
  logic [4:0]         sel_w_q;
  logic [WIDTH-1:0]   result_q;

  logic [ACC_W-1:0]   acc_d;
  logic [WIDTH-1:0]   result_d;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  // One iteration step: shift-add for multiply, restoring step for divide
  always_comb begin
    mul_sum   = {1'b0, acc_q[ACC_W-1:WIDTH]}
              + (acc_q[0] ? {1'b0, opb_q} : (WIDTH+1)'(0));
    div_shift = {acc_q[ACC_W-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_diff  = div_shift[WIDTH-1:0] - opb_q;
    acc_d     = acc_q;
    if (op_q[1]) begin
      if (div_ge) acc_d = {div_diff, acc_q[WIDTH-2:0], 1'b1};
      else        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Final result selection, sign fix-up and divide-by-zero override
  always_comb begin
    quot     = acc_q[WIDTH-1:0];
    result_d = '0;
    case (op_q)
      OP_MUL:   result_d = acc_q[WIDTH-1:0];
      OP_UMULH: result_d = acc_q[ACC_W-1:WIDTH];
      default: begin
        if (opb_q == '0)  result_d = '0;
        else if (neg_q)   result_d = (~quot) + WIDTH'(1);
        else              result_d = quot;
      end
    endcase
  end

  always_comb begin
    abs_a = a[WIDTH-1] ? (~a) + WIDTH'(1) : a;
    abs_b = b[WIDTH-1] ? (~b) + WIDTH'(1) : b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sel_w_q  <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q    <= op;
            sel_w_q <= dest;
            cnt_q   <= CNT_W'(WIDTH - 1);
            busy_q  <= 1'b1;
            state_q <= S_RUN;
            neg_q   <= (op == OP_SDIV) && (a[WIDTH-1] ^ b[WIDTH-1]);
            if (op == OP_SDIV) begin
              opb_q <= abs_b;
              acc_q <= {WIDTH'(0), abs_a};
            end else if (op[1]) begin
              opb_q <= b;
              acc_q <= {WIDTH'(0), a};
            end else begin
              // Multiplier sits in the low half and shifts out as partial products accumulate
              opb_q <= a;
              acc_q <= {WIDTH'(0), b};
            end
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_q <= S_FIX;
        end
        S_FIX: begin
          result_q <= result_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_DONE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign write  = done_q;
  assign sel_w  = sel_w_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected results queued at issue, compared at done.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [63:0] a;
  logic [63:0] b;
  logic [4:0]  dest;
  logic        busy;
  logic        done;
  logic        write;
  logic [4:0]  sel_w;
  logic [63:0] result;

  typedef struct {
    logic [63:0] result;
    logic [4:0]  sel_w;
  } exp_t;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fail    = 0;

  muldiv_unit #(.WIDTH(64), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .dest(dest),
    .busy(busy), .done(done), .write(write), .sel_w(sel_w), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Issue one op, optionally pulse a competing start at cycle inj, then check the result
  task automatic run_op(input string name, input logic [1:0] o, input logic [63:0] x,
                        input logic [63:0] y, input logic [4:0] d,
                        input logic [63:0] exp_r, input int inj);
    exp_t e;
    int   k;
    e.result = exp_r;
    e.sel_w  = d;
    sb.push_back(e);
    @(negedge clk);
    op = o; a = x; b = y; dest = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = ~o; dest = ~d;
    check({name, "_busy"}, 128'(busy), 128'(1));
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (inj != 0 && k == inj) begin
        start = 1'b1; op = 2'b00; a = 64'd3; b = 64'd3; dest = 5'd9;
      end else begin
        start = 1'b0;
      end
      if (done) break;
    end
    start = 1'b0;
    check({name, "_latency"}, 128'(k), 128'(65));
    e = sb.pop_front();
    check({name, "_result"}, 128'(result), 128'(e.result));
    check({name, "_sel_w"}, 128'(sel_w), 128'(e.sel_w));
    check({name, "_write"}, 128'(write), 128'(1));
    check({name, "_busy_at_done"}, 128'(busy), 128'(0));
    @(negedge clk);
    check({name, "_done_pulse"}, 128'({done, write}), 128'(0));
    check({name, "_held"}, 128'(result), 128'(e.result));
  endtask

  initial begin
    int dcount;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; dest = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done_write", 128'({done, write}), 128'(0));
    check("rst_result", 128'(result), 128'(0));
    check("rst_sel_w", 128'(sel_w), 128'(0));
    reset = 1'b0;

    run_op("mul_x2", 2'b00, 64'h1234567812345678, 64'd2, 5'd5, 64'h2468ACF02468ACF0, 0);
    run_op("umulh_max", 2'b01, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd6,
           64'hFFFFFFFFFFFFFFFE, 0);
    run_op("mul_max", 2'b00, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd7,
           64'h0000000000000001, 0);
    run_op("umulh_pow", 2'b01, 64'h8000000000000000, 64'd4, 5'd8, 64'd2, 0);
    run_op("udiv", 2'b10, 64'h00000000FFFFFFFF, 64'h10, 5'd9, 64'h000000000FFFFFFF, 0);
    run_op("udiv_zero", 2'b10, 64'h123456789, 64'd0, 5'd10, 64'd0, 0);
    run_op("sdiv_neg", 2'b11, 64'hFFFFFFFFFFFFFF9C, 64'd7, 5'd11, 64'hFFFFFFFFFFFFFFF2, 0);
    run_op("sdiv_negb", 2'b11, 64'd100, 64'hFFFFFFFFFFFFFFF9, 5'd12, 64'hFFFFFFFFFFFFFFF2, 0);
    run_op("sdiv_both", 2'b11, 64'hFFFFFFFFFFFFFF9C, 64'hFFFFFFFFFFFFFFF9, 5'd13, 64'd14, 0);
    run_op("sdiv_ovf", 2'b11, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'd14,
           64'h8000000000000000, 0);
    run_op("sdiv_zero", 2'b11, 64'hFFFFFFFFFFFFFF9C, 64'd0, 5'd15, 64'd0, 0);

    // Competing start while busy must be dropped: one done, result unchanged afterwards
    run_op("busy_start", 2'b10, 64'd1000, 64'd10, 5'd7, 64'd100, 10);
    dcount = 0;
    repeat (70) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("busy_start_extra_done", 128'(dcount), 128'(0));
    check("busy_start_result", 128'(result), 128'(100));

    // Reset mid-operation aborts without done
    @(negedge clk);
    op = 2'b00; a = 64'd5; b = 64'd6; dest = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_result", 128'(result), 128'(0));
    check("abort_sel_w", 128'(sel_w), 128'(0));
    dcount = 0;
    repeat (70) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("abort_no_activity", 128'(dcount), 128'(0));

    run_op("after_abort", 2'b00, 64'd5, 64'd6, 5'd3, 64'd30, 0);
    check("sb_empty", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative 64-bit multiply/divide execution unit. Sits directly downstream of the register file.
- Consumes the two read-port values (data_out1 -> a, data_out2 -> b) plus the destination register index.
- Returns the result, a write strobe and a destination index to drive the register file write port (data_in, write, sel_w).
- Covers the LEGv8 MUL, UMULH, UDIV and SDIV instructions. The core ALU does not implement them.

Parameters:
- WIDTH, 64, operand/result width in bits.
- CNT_W, 6, iteration counter width (log2 WIDTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  00 MUL (low 64 bits of product), 01 UMULH (high 64 bits, unsigned), 10 UDIV, 11 SDIV.
- a  input  WIDTH  operand 1 (multiplicand/dividend), from data_out1.
- b  input  WIDTH  operand 2 (multiplier/divisor), from data_out2.
- dest  input  5  destination register index, latched with the operands.
- busy  output  1  high while an operation is in flight; the processor stalls PC on busy.
- done  output  1  one-cycle pulse; result valid.
- write  output  1  register-file write enable; equal to done.
- sel_w  output  5  latched dest, valid with done.
- result  output  WIDTH  operation result; holds its value until the next accepted start.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: state = IDLE; busy, done, write = 0; result = 0; sel_w = 0; counter = 0.
- State machine: IDLE -> RUN -> FIX -> DONE -> IDLE.
- IDLE:
  - If start = 1 at edge n: latch a, b, op and dest; load counter = WIDTH-1; go to RUN.
  - busy = 1 from edge n onward.
  - For SDIV, latch the absolute values of the operands and record the quotient sign = a[63] XOR b[63].
- RUN: one iteration per cycle.
  - MUL/UMULH: radix-2 shift-add into a 128-bit product register.
  - UDIV/SDIV: restoring division, one quotient bit per cycle, 64-bit remainder register.
  - The counter decrements each cycle. Leave RUN on the edge where counter = 0, i.e. after exactly WIDTH iterations (edge n+64).
- FIX (edge n+65 leaves FIX):
  - Select the low or high product half.
  - Negate the quotient if the SDIV sign is set.
  - Apply the special cases below.
  - Register result, drive done = write = 1 and busy = 0, go to DONE.
- DONE: lasts exactly one cycle, then IDLE; done and write return to 0. Latency from start sampled to done high: 65 cycles.
- start is ignored while busy = 1 and during DONE. No queuing; the request is dropped.
- Special cases:
  - Divide by zero (b = 0, UDIV or SDIV): result = 0, no trap. Still takes the full 65 cycles.
  - SDIV of 0x8000000000000000 by 0xFFFFFFFFFFFFFFFF: result = 0x8000000000000000.
  - SDIV truncates toward zero. The remainder is discarded.
  - MUL is sign-agnostic (low 64 bits identical for signed and unsigned). UMULH treats both operands as unsigned.
- Operand changes on a/b/op/dest after acceptance have no effect.
- Reset mid-operation (any state): next edge returns to IDLE with the reset values above. No done or write is produced for the aborted operation.
- Reset and start asserted together: reset wins; the operation is not accepted.

Test Plan:
- MUL: a = 0x1234567812345678, b = 2, dest = 5, start one cycle -> busy for 65 cycles; then done = write = 1 for one cycle with result = 0x2468ACF02468ACF0 and sel_w = 5.
- UMULH: a = b = 0xFFFFFFFFFFFFFFFF -> result = 0xFFFFFFFFFFFFFFFE. Same operands with MUL -> result = 0x0000000000000001.
- UDIV: a = 0x00000000FFFFFFFF, b = 0x10 -> result = 0x000000000FFFFFFF. Divide-by-zero case: b = 0 -> result = 0, done still at cycle 65.
- SDIV:
  - a = -100 (0xFFFFFFFFFFFFFF9C), b = 7 -> result = 0xFFFFFFFFFFFFFFF2 (-14).
  - a = 0x8000000000000000, b = -1 -> result = 0x8000000000000000.
- start pulsed again at cycle 10 with different operands while busy -> ignored; the first result is unchanged and exactly one done pulse occurs.
- reset asserted at cycle 30 of a MUL -> busy = 0, result = 0 and sel_w = 0 after the next edge, no done. A fresh start afterwards completes normally in 65 cycles.
